serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor computing a − b − bin over Bits clock cycles, one bit per cycle, LSB first. It is the sequential, inverse-operation counterpart of the combinational ripple-carry adder in the sumadores library. It serves area-constrained datapaths where a ripple chain of Bits cells is too large. The block accepts operands with a start/ready handshake and signals completion with a one-cycle done pulse.

---
 rtl/sumadores_pkg.sv | 13 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_subtractor.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sumadores_pkg.sv
// Shared types and constants for the sumadores arithmetic blocks.
// Holds the serial subtractor FSM encoding and default width.
package sumadores_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sub_state_t;

  localparam int unsigned DEFAULT_BITS = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow-out.
// Combinational; reused once per cycle by the serial loop.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Result and borrow-out are registered on the final shift edge.
module serial_subtractor
  import sumadores_pkg::*;
#(
  parameter int unsigned Bits = DEFAULT_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [Bits-1:0] a,
  input  logic [Bits-1:0] b,
  input  logic            bin,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [Bits-1:0] diff,
  output logic            bout
);

  localparam int CW = $clog2(Bits + 1);

  sub_state_t      state_q, state_d;
  logic [Bits-1:0] a_q, a_d;
  logic [Bits-1:0] b_q, b_d;
  logic [Bits-1:0] res_q, res_d;
  logic [Bits-1:0] diff_q, diff_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            brw_q, brw_d;
  logic            bout_q, bout_d;

  logic            fs_d;
  logic            fs_bo;
  logic            last_bit;
  logic            accept;
  logic [Bits-1:0] d_ext;

  full_subtractor u_cell (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (brw_q),
    .d    (fs_d),
    .bout (fs_bo)
  );

  assign last_bit = (state_q == SHIFT) &&
                    (cnt_q == CW'(Bits - 1));
  assign accept   = (state_q == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
    busy  = !ready;
    done  = (state_q == DONE);
    diff  = diff_q;
    bout  = bout_q;
  end

  // New result bit enters at the MSB; works for Bits == 1 too.
  always_comb begin
    d_ext          = '0;
    d_ext[Bits-1]  = fs_d;
    a_d            = a_q;
    b_d            = b_q;
    res_d          = res_q;
    brw_d          = brw_q;
    cnt_d          = cnt_q;
    diff_d         = diff_q;
    bout_d         = bout_q;
    if (accept) begin
      a_d   = a;
      b_d   = b;
      brw_d = bin;
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      res_d = (res_q >> 1) | d_ext;
      brw_d = fs_bo;
      cnt_d = cnt_q + CW'(1);
      if (last_bit) begin
        diff_d = (res_q >> 1) | d_ext;
        bout_d = fs_bo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      diff_q <= '0;
      cnt_q  <= '0;
      brw_q  <= 1'b0;
      bout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      diff_q <= diff_d;
      cnt_q  <= cnt_d;
      brw_q  <= brw_d;
      bout_q <= bout_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor at Bits=8.
// Inputs change #1 after posedge; outputs sampled on negedge.
module tb_serial_subtractor;

  localparam int BITS = 8;

  logic            clk;
  logic            rst;
  logic            start;
  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic            bin;
  logic            ready;
  logic            busy;
  logic            done;
  logic [BITS-1:0] diff;
  logic            bout;

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.Bits(BITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (!ready) check({tag, "/rdy_to"}, 32'(ready), 32'd1);
  endtask

  task automatic run_op(input string tag,
                        input logic [7:0] ia,
                        input logic [7:0] ib,
                        input logic ibin,
                        input logic [7:0] ediff,
                        input logic ebout);
    int  n;
    bit  rdy_low;
    wait_ready(tag);
    a     = ia;
    b     = ib;
    bin   = ibin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    bin   = 1'($urandom);
    n       = 0;
    rdy_low = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!done && ready) rdy_low = 1'b0;
    end while (!done && n < 20);
    check({tag, "/latency"}, 32'(n - 1), 32'(BITS));
    check({tag, "/diff"}, 32'(diff), 32'(ediff));
    check({tag, "/bout"}, 32'(bout), 32'(ebout));
    check({tag, "/rdy_low"}, 32'(rdy_low), 32'd1);
    @(negedge clk);
    check({tag, "/pulse1"}, 32'(done), 32'd0);
  endtask

  logic [7:0] bb_a [3] = '{8'h12, 8'h05, 8'hC3};
  logic [7:0] bb_b [3] = '{8'h02, 8'h07, 8'h3C};
  logic       bb_i [3] = '{1'b1, 1'b0, 1'b1};
  logic [8:0] bb_e [3] = '{9'h00F, 9'h1FE, 9'h086};

  initial begin
    int         n;
    int         nd;
    int         last;
    bit         seen;
    bit         was_rdy;
    int         ld;
    logic [7:0] ra, rb;
    logic       ri;
    logic [8:0] r;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #12;
    check("rst/ready", 32'(ready), 32'd1);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/diff", 32'(diff), 32'd0);
    check("rst/bout", 32'(bout), 32'd0);
    rst = 1'b0;

    run_op("v5a23", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
    run_op("v1020", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);
    run_op("v0000", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    run_op("vffff", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    run_op("v807f", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

    // Second start mid-shift must be ignored.
    wait_ready("ign");
    a     = 8'h40;
    b     = 8'h01;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 8'h00;
    b     = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    n    = 0;
    seen = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!done && diff !== 8'h00) seen = 1'b0;
    end while (!done && n < 20);
    check("ign/hold", 32'(seen), 32'd1);
    check("ign/done", 32'(done), 32'd1);
    check("ign/diff", 32'(diff), 32'h3F);
    check("ign/bout", 32'(bout), 32'd0);
    @(negedge clk);

    // Asynchronous reset between SHIFT edges 3 and 4.
    wait_ready("rst2");
    a     = 8'h55;
    b     = 8'h11;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst/ready", 32'(ready), 32'd1);
    check("arst/busy", 32'(busy), 32'd0);
    check("arst/done", 32'(done), 32'd0);
    check("arst/diff", 32'(diff), 32'd0);
    check("arst/bout", 32'(bout), 32'd0);
    #2 rst = 1'b0;
    seen = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("arst/nodone", 32'(seen), 32'd0);
    run_op("v0903", 8'h09, 8'h03, 1'b0, 8'h06, 1'b0);

    // start held high: back-to-back issue.
    wait_ready("b2b");
    a       = bb_a[0];
    b       = bb_b[0];
    bin     = bb_i[0];
    start   = 1'b1;
    ld      = 0;
    nd      = 0;
    last    = 0;
    was_rdy = 1'b1;
    for (int cyc = 0; cyc < 45 && nd < 3; cyc++) begin
      @(posedge clk);
      #1;
      if (was_rdy && ld < 2) begin
        ld++;
        a   = bb_a[ld];
        b   = bb_b[ld];
        bin = bb_i[ld];
      end
      @(negedge clk);
      if (done) begin
        check($sformatf("b2b%0d/diff", nd), 32'(diff),
              32'(bb_e[nd][7:0]));
        check($sformatf("b2b%0d/bout", nd), 32'(bout),
              32'(bb_e[nd][8]));
        if (nd > 0)
          check($sformatf("b2b%0d/gap", nd), 32'(cyc - last),
                32'd10);
        last = cyc;
        nd++;
      end
      was_rdy = ready;
    end
    check("b2b/count", 32'(nd), 32'd3);
    start = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ri = 1'($urandom);
      r  = {1'b0, ra} - {1'b0, rb} - {8'd0, ri};
      run_op($sformatf("rnd%0d", i), ra, rb, ri, r[7:0], r[8]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
